// File: rtl/parity_check_arbiter_if.sv
// Request/response bundle for the shared parity checker.
// The slave modport is the arbiter side; the master modport is the client side.
interface parity_check_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_data;
   logic                      rsp_even;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_even
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_even
   );
endinterface

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter in front of one even/odd classifier, one job in flight.
// Define PARITY_ARB_STATS_EN to add saturating even/odd response counters.
module parity_check_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4
`ifdef PARITY_ARB_STATS_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic clk,
   input  logic rst_n,
   parity_check_arbiter_if.slave bus,
   output logic busy
`ifdef PARITY_ARB_STATS_EN
   , output logic [CNT_W-1:0] even_count,
   output logic [CNT_W-1:0] odd_count
`endif
);
   localparam int ID_W = $clog2(NUM_REQ);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   win_q, win_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_even_q, rsp_even_d;

   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   cand;
   logic              found;
   int                idx;

   // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      win_id = '0;
      cand   = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx  = (int'(rr_ptr_q) + k) % NUM_REQ;
         cand = ID_W'(idx);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            win_id = cand;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      win_d         = win_q;
      data_d        = data_q;
      rsp_id_d      = rsp_id_q;
      rsp_data_d    = rsp_data_q;
      rsp_even_d    = rsp_even_q;
      bus.req_ready = '0;
      unique case (1'b1)
         (state_q == IDLE): begin
            if (found && rst_n) begin
               bus.req_ready[win_id] = 1'b1;
               win_d   = win_id;
               data_d  = bus.req_data[win_id*DATA_W +: DATA_W];
               state_d = CHECK;
            end
         end
         (state_q == CHECK): begin
            rsp_id_d   = win_q;
            rsp_data_d = data_q;
            rsp_even_d = ~data_q[0];
            state_d    = RESP;
         end
         (state_q == RESP): begin
            if (bus.rsp_ready) begin
               state_d  = IDLE;
               rr_ptr_d = (win_q == ID_W'(NUM_REQ - 1)) ?
                          '0 : win_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         win_q      <= '0;
         data_q     <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_even_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         win_q      <= win_d;
         data_q     <= data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_even_q <= rsp_even_d;
      end
   end

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_even  = rsp_even_q;
   assign busy          = (state_q != IDLE);

`ifdef PARITY_ARB_STATS_EN
   logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
   logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;
   logic             rsp_hs;

   assign rsp_hs = bus.rsp_valid & bus.rsp_ready;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      even_cnt_d = even_cnt_q;
      odd_cnt_d  = odd_cnt_q;
      if (rsp_hs && rsp_even_q && (even_cnt_q != '1))
         even_cnt_d = even_cnt_q + 1'b1;
      if (rsp_hs && !rsp_even_q && (odd_cnt_q != '1))
         odd_cnt_d = odd_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         even_cnt_q <= '0;
         odd_cnt_q  <= '0;
      end else begin
         even_cnt_q <= even_cnt_d;
         odd_cnt_q  <= odd_cnt_d;
      end
   end

   assign even_count = even_cnt_q;
   assign odd_count  = odd_cnt_q;
`endif
endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed bench for parity_check_arbiter: vector table plus corner sequences.
// Build with PARITY_ARB_STATS_EN to also exercise the saturating counters.
module tb_parity_check_arbiter;
   logic clk;
   logic rst_n;
   logic busy;
`ifdef PARITY_ARB_STATS_EN
   logic [1:0] even_count;
   logic [1:0] odd_count;
`endif

   int checks;
   int failures;

   parity_check_arbiter_if #(.NUM_REQ(4), .DATA_W(4)) bus ();

   parity_check_arbiter #(
      .NUM_REQ(4),
      .DATA_W (4)
`ifdef PARITY_ARB_STATS_EN
      , .CNT_W(2)
`endif
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave),
      .busy (busy)
`ifdef PARITY_ARB_STATS_EN
      , .even_count(even_count),
      .odd_count (odd_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  vld;
      logic [15:0] dat;
      logic [3:0]  rdy;
      logic [1:0]  id;
      logic [3:0]  d;
      logic        ev;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Present one request and follow it to completion with rsp_ready high.
   task automatic do_txn(input logic [3:0] v, input logic [15:0] d,
                         input logic [3:0] er, input logic [1:0] eid,
                         input logic [3:0] ed, input logic ee);
      bus.req_valid = v;
      bus.req_data  = d;
      bus.rsp_ready = 1'b1;
      #1;
      check("grant", bus.req_ready, er);
      @(posedge clk); #1;
      bus.req_valid = '0;
      bus.req_data  = 16'($urandom);
      check("check_busy", busy, 1);
      check("check_noready", bus.req_ready, 0);
      check("check_novalid", bus.rsp_valid, 0);
      @(posedge clk); #1;
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_id", bus.rsp_id, eid);
      check("rsp_data", bus.rsp_data, ed);
      check("rsp_even", bus.rsp_even, ee);
      @(posedge clk); #1;
      check("rsp_drop", bus.rsp_valid, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vt[0] = '{4'b0001, 16'hF3A6, 4'b0001, 2'd0, 4'd6,  1'b1};
      vt[1] = '{4'b0100, 16'h1F23, 4'b0100, 2'd2, 4'd15, 1'b0};
      vt[2] = '{4'b0100, 16'h5042, 4'b0100, 2'd2, 4'd0,  1'b1};
      vt[3] = '{4'b1111, 16'hA321, 4'b1000, 2'd3, 4'd10, 1'b1};
      vt[4] = '{4'b1010, 16'h2D70, 4'b0010, 2'd1, 4'd7,  1'b0};
      vt[5] = '{4'b0011, 16'hFFF8, 4'b0001, 2'd0, 4'd8,  1'b1};
      vt[6] = '{4'b0001, 16'h0001, 4'b0001, 2'd0, 4'd1,  1'b0};
      vt[7] = '{4'b1001, 16'hE003, 4'b1000, 2'd3, 4'd14, 1'b1};

      rst_n         = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_data  = 16'h1234;
      bus.rsp_ready = 1'b1;
      #12;
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rsp_even", bus.rsp_even, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", bus.req_ready, 0);
      bus.req_valid = '0;
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_no_grant", bus.req_ready, 0);

      for (int i = 0; i < 8; i++)
         do_txn(vt[i].vld, vt[i].dat, vt[i].rdy, vt[i].id, vt[i].d, vt[i].ev);

      // All requesters held valid: grants rotate, one response per 3 cycles.
      bus.req_valid = 4'b1111;
      bus.req_data  = {4'd10, 4'd7, 4'd4, 4'd1};
      #1;
      for (int g = 0; g < 5; g++) begin
         check("rr_grant", bus.req_ready, 4'b0001 << (g % 4));
         @(posedge clk); #1;
         check("rr_pending", bus.rsp_valid, 0);
         @(posedge clk); #1;
         check("rr_rsp_valid", bus.rsp_valid, 1);
         check("rr_rsp_id", bus.rsp_id, g % 4);
         check("rr_rsp_even", bus.rsp_even, (g % 2) == 1);
         @(posedge clk); #1;
      end
      bus.req_valid = '0;
      @(posedge clk); #1;

      // Backpressure on requester 1 with data 9; pointer now at 1.
      bus.req_valid = 4'b0010;
      bus.req_data  = 16'h0090;
      bus.rsp_ready = 1'b0;
      #1;
      check("bp_grant", bus.req_ready, 4'b0010);
      @(posedge clk); #1;
      bus.req_valid = 4'b1111;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", bus.rsp_valid, 1);
         check("bp_data", bus.rsp_data, 9);
         check("bp_even", bus.rsp_even, 0);
         check("bp_id", bus.rsp_id, 1);
         check("bp_noready", bus.req_ready, 0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_done", bus.rsp_valid, 0);
      check("bp_next_grant", bus.req_ready, 4'b0100);
      bus.req_valid = '0;
      @(posedge clk); #1;

      // Reset while in CHECK discards the job and rewinds the pointer.
      bus.req_valid = 4'b0100;
      bus.req_data  = 16'h0200;
      #1;
      check("mr_grant", bus.req_ready, 4'b0100);
      @(posedge clk); #1;
      bus.req_valid = '0;
      check("mr_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mr_rsp_valid", bus.rsp_valid, 0);
      check("mr_busy", busy, 0);
      check("mr_rsp_data", bus.rsp_data, 0);
      #2 rst_n = 1'b1;
      do_txn(4'b1000, 16'h5000, 4'b1000, 2'd3, 4'd5, 1'b0);
      check("mr_no_stray", bus.rsp_valid, 0);

`ifdef PARITY_ARB_STATS_EN
      rst_n = 1'b0;
      #1;
      check("st_rst_even", even_count, 0);
      check("st_rst_odd", odd_count, 0);
      #3 rst_n = 1'b1;
      do_txn(4'b0001, 16'h0002, 4'b0001, 2'd0, 4'd2, 1'b1);
      do_txn(4'b0001, 16'h0004, 4'b0001, 2'd0, 4'd4, 1'b1);
      do_txn(4'b0001, 16'h0006, 4'b0001, 2'd0, 4'd6, 1'b1);
      check("st_even3", even_count, 3);
      do_txn(4'b0001, 16'h0008, 4'b0001, 2'd0, 4'd8, 1'b1);
      do_txn(4'b0001, 16'h0000, 4'b0001, 2'd0, 4'd0, 1'b1);
      do_txn(4'b0001, 16'h0003, 4'b0001, 2'd0, 4'd3, 1'b0);
      check("st_even_sat", even_count, 3);
      check("st_odd", odd_count, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
